// File: rtl/rv_decode_stage.sv
// rv_decode_stage: registered RV32I decode stage between fetch and execute.
//
// Splits each accepted instruction into its fields, builds the sign-extended
// immediate and classifies its format. The decoded entry is registered, so
// every out_* comes straight from flops. A main register plus a skid
// register keep full throughput under backpressure; in_ready depends only
// on registered state (and reset), never on out_ready.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   flush               discard all held entries; the input of that cycle is dropped
//   in_valid/in_ready   upstream handshake; in_instr/in_pc carried with it
//   out_valid/out_ready downstream handshake
//   out_pc .. out_fmt   decoded fields, immediate and format code of the main entry
//   out_illegal         opcode outside the RV32I base set
//
// Configuration macro:
//   DECODE_ILLEGAL_CHECK_EN  when defined, out_illegal flags unknown formats,
//                            non-32-bit encodings and bad funct7 on OP; when
//                            undefined out_illegal is tied to 0.

module rv_decode_stage #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned PC_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [4:0]      out_rd,
  output logic [2:0]      out_funct3,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [6:0]      out_funct7,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal
);

  // Format codes
  localparam logic [2:0] FmtR   = 3'd0;
  localparam logic [2:0] FmtI   = 3'd1;
  localparam logic [2:0] FmtS   = 3'd2;
  localparam logic [2:0] FmtB   = 3'd3;
  localparam logic [2:0] FmtU   = 3'd4;
  localparam logic [2:0] FmtJ   = 3'd5;
  localparam logic [2:0] FmtUnk = 3'd7;

  // RV32I base opcodes
  localparam logic [6:0] OpOp     = 7'h33;
  localparam logic [6:0] OpLoad   = 7'h03;
  localparam logic [6:0] OpOpImm  = 7'h13;
  localparam logic [6:0] OpJalr   = 7'h67;
  localparam logic [6:0] OpSystem = 7'h73;
  localparam logic [6:0] OpFence  = 7'h0F;
  localparam logic [6:0] OpStore  = 7'h23;
  localparam logic [6:0] OpBranch = 7'h63;
  localparam logic [6:0] OpLui    = 7'h37;
  localparam logic [6:0] OpAuipc  = 7'h17;
  localparam logic [6:0] OpJal    = 7'h6F;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
  } entry_t;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StFull  = 2'd1,
    StSkid  = 2'd2
  } state_e;

  state_e state_q, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  entry_t dec;

  logic        in_xfer;
  logic        out_xfer;
  logic [31:0] imm32;
  logic [2:0]  fmt;
  logic        illegal;

  // ---------------------------------------------------------------------------
  // Combinational decode of the incoming word
  // ---------------------------------------------------------------------------
  always_comb begin
    imm32 = 32'h0;
    fmt   = FmtUnk;
    unique case (in_instr[6:0])
      OpOp: begin
        fmt   = FmtR;
        imm32 = 32'h0;
      end
      OpLoad, OpOpImm, OpJalr, OpSystem, OpFence: begin
        fmt   = FmtI;
        imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      OpStore: begin
        fmt   = FmtS;
        imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      OpBranch: begin
        fmt   = FmtB;
        imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                 in_instr[11:8], 1'b0};
      end
      OpLui, OpAuipc: begin
        fmt   = FmtU;
        imm32 = {in_instr[31:12], 12'h000};
      end
      OpJal: begin
        fmt   = FmtJ;
        imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                 in_instr[30:21], 1'b0};
      end
      default: begin
        fmt   = FmtUnk;
        imm32 = 32'h0;
      end
    endcase
  end

`ifdef DECODE_ILLEGAL_CHECK_EN
  // OP only defines funct7 = 0x00 (base) and 0x20 (SUB/SRA) in RV32I.
  assign illegal = (fmt == FmtUnk) || (in_instr[1:0] != 2'b11) ||
                   ((in_instr[6:0] == OpOp) && (in_instr[31:25] != 7'h00) &&
                    (in_instr[31:25] != 7'h20));
`else
  assign illegal = 1'b0;
`endif

  always_comb begin
    dec.pc      = in_pc;
    dec.opcode  = in_instr[6:0];
    dec.rd      = in_instr[11:7];
    dec.funct3  = in_instr[14:12];
    dec.rs1     = in_instr[19:15];
    dec.rs2     = in_instr[24:20];
    dec.funct7  = in_instr[31:25];
    // Signed cast sign-extends the 32-bit immediate to any XLEN >= 32.
    dec.imm     = XLEN'(signed'(imm32));
    dec.fmt     = fmt;
    dec.illegal = illegal;
  end

  // ---------------------------------------------------------------------------
  // Handshake FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  // ---------------------------------------------------------------------------
  // Handshake FSM: next state and entry movement
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // Held data is left in place; only validity is dropped.
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (in_xfer) begin
            state_d = StFull;
            main_d  = dec;
          end
        end
        StFull: begin
          if (in_xfer && out_xfer) begin
            main_d = dec;
          end else if (in_xfer) begin
            state_d = StSkid;
            skid_d  = dec;
          end else if (out_xfer) begin
            state_d = StEmpty;
          end
        end
        StSkid: begin
          if (out_xfer) begin
            state_d = StFull;
            main_d  = skid_q;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Handshake FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready    = rst_n && (state_q != StSkid);
    out_valid   = (state_q != StEmpty);
    out_pc      = main_q.pc;
    out_opcode  = main_q.opcode;
    out_rd      = main_q.rd;
    out_funct3  = main_q.funct3;
    out_rs1     = main_q.rs1;
    out_rs2     = main_q.rs2;
    out_funct7  = main_q.funct7;
    out_imm     = main_q.imm;
    out_fmt     = main_q.fmt;
    out_illegal = main_q.illegal;
  end

endmodule

// File: tb/tb_rv_decode_stage.sv
// Directed bench for rv_decode_stage with a scoreboard of expected entries.
module tb_rv_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [6:0]  out_opcode;
  logic [4:0]  out_rd;
  logic [2:0]  out_funct3;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [6:0]  out_funct7;
  logic [31:0] out_imm;
  logic [2:0]  out_fmt;
  logic        out_illegal;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        illegal;
  } exp_t;

  exp_t sb[$];

  rv_decode_stage #(
    .XLEN(32),
    .PC_W(32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .in_pc      (in_pc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pc     (out_pc),
    .out_opcode (out_opcode),
    .out_rd     (out_rd),
    .out_funct3 (out_funct3),
    .out_rs1    (out_rs1),
    .out_rs2    (out_rs2),
    .out_funct7 (out_funct7),
    .out_imm    (out_imm),
    .out_fmt    (out_fmt),
    .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference decode written straight from the instruction-format tables.
  function automatic exp_t model(input logic [31:0] i, input logic [31:0] pc);
    exp_t e;
    e.pc     = pc;
    e.opcode = i[6:0];
    e.rd     = i[11:7];
    e.funct3 = i[14:12];
    e.rs1    = i[19:15];
    e.rs2    = i[24:20];
    e.funct7 = i[31:25];
    case (i[6:0])
      7'h33:                             begin e.fmt = 3'd0; e.imm = 32'h0; end
      7'h03, 7'h13, 7'h67, 7'h73, 7'h0F: begin e.fmt = 3'd1; e.imm = {{20{i[31]}}, i[31:20]}; end
      7'h23: begin e.fmt = 3'd2; e.imm = {{20{i[31]}}, i[31:25], i[11:7]}; end
      7'h63: begin
        e.fmt = 3'd3;
        e.imm = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
      end
      7'h37, 7'h17: begin e.fmt = 3'd4; e.imm = {i[31:12], 12'h0}; end
      7'h6F: begin
        e.fmt = 3'd5;
        e.imm = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
      end
      default: begin e.fmt = 3'd7; e.imm = 32'h0; end
    endcase
`ifdef DECODE_ILLEGAL_CHECK_EN
    e.illegal = (e.fmt == 3'd7) || (i[1:0] != 2'b11) ||
                (i[6:0] == 7'h33 && i[31:25] != 7'h00 && i[31:25] != 7'h20);
`else
    e.illegal = 1'b0;
`endif
    return e;
  endfunction

  // Output side of the scoreboard: compare on every output transfer.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      check("sb_entry_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("sb_pc", 64'(out_pc), 64'(e.pc));
        check("sb_opcode", 64'(out_opcode), 64'(e.opcode));
        check("sb_rd", 64'(out_rd), 64'(e.rd));
        check("sb_funct3", 64'(out_funct3), 64'(e.funct3));
        check("sb_rs1", 64'(out_rs1), 64'(e.rs1));
        check("sb_rs2", 64'(out_rs2), 64'(e.rs2));
        check("sb_funct7", 64'(out_funct7), 64'(e.funct7));
        check("sb_imm", 64'(out_imm), 64'(e.imm));
        check("sb_fmt", 64'(out_fmt), 64'(e.fmt));
        check("sb_illegal", 64'(out_illegal), 64'(e.illegal));
      end
    end
  end

  // One clock: record an accepted input, drop the model on flush/reset.
  task automatic step();
    if (!rst_n || flush) sb.delete();
    else if (in_valid && in_ready) sb.push_back(model(in_instr, in_pc));
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] instr, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = 32'h0;
    in_pc     = 32'h0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_imm", 64'(out_imm), 64'd0);
    check("rst_out_pc", 64'(out_pc), 64'd0);
    rst_n = 1'b1;
    step();
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Single decodes
    send(32'hFFF10093, 32'h100);
    check("addi_valid", 64'(out_valid), 64'd1);
    check("addi_opcode", 64'(out_opcode), 64'h13);
    check("addi_rd", 64'(out_rd), 64'd1);
    check("addi_rs1", 64'(out_rs1), 64'd2);
    check("addi_imm", 64'(out_imm), 64'hFFFFFFFF);
    check("addi_fmt", 64'(out_fmt), 64'd1);
    send(32'h00512423, 32'h104);
    check("sw_opcode", 64'(out_opcode), 64'h23);
    check("sw_funct3", 64'(out_funct3), 64'd2);
    check("sw_rs1", 64'(out_rs1), 64'd2);
    check("sw_rs2", 64'(out_rs2), 64'd5);
    check("sw_imm", 64'(out_imm), 64'h8);
    check("sw_fmt", 64'(out_fmt), 64'd2);
    send(32'hFE000EE3, 32'h108);
    check("beq_opcode", 64'(out_opcode), 64'h63);
    check("beq_imm", 64'(out_imm), 64'hFFFFFFFC);
    check("beq_fmt", 64'(out_fmt), 64'd3);
    send(32'h123450B7, 32'h10C);
    check("lui_rd", 64'(out_rd), 64'd1);
    check("lui_imm", 64'(out_imm), 64'h12345000);
    check("lui_fmt", 64'(out_fmt), 64'd4);
    send(32'h002081B3, 32'h110);
    check("add_fmt", 64'(out_fmt), 64'd0);
    check("add_imm", 64'(out_imm), 64'd0);
    send(32'h0080006F, 32'h114);
    check("jal_imm", 64'(out_imm), 64'h8);
    check("jal_fmt", 64'(out_fmt), 64'd5);
    step();
    check("idle_out_valid", 64'(out_valid), 64'd0);

    // Backpressure: third instruction must stall
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h00100093; in_pc = 32'h200; step();
    check("bp_ready_after_1", 64'(in_ready), 64'd1);
    in_instr  = 32'h00200113; in_pc = 32'h204; step();
    check("bp_ready_after_2", 64'(in_ready), 64'd0);
    check("bp_out_pc_first", 64'(out_pc), 64'h200);
    in_instr  = 32'h00300193; in_pc = 32'h208; step();
    check("bp_still_stalled", 64'(in_ready), 64'd0);
    check("bp_hold_pc", 64'(out_pc), 64'h200);
    check("bp_accepted", 64'(sb.size()), 64'd2);
    out_ready = 1'b1;
    step();
    check("bp_drain_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    step();
    step();
    check("bp_all_out", 64'(sb.size()), 64'd0);
    check("bp_idle", 64'(out_valid), 64'd0);

    // Flush from SKID with an input in the same cycle
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h00400213; in_pc = 32'h300; step();
    in_instr  = 32'h00500293; in_pc = 32'h304; step();
    check("fl_in_skid", 64'(in_ready), 64'd0);
    in_instr  = 32'h00600313; in_pc = 32'h308; flush = 1'b1; step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl_out_valid", 64'(out_valid), 64'd0);
    check("fl_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    repeat (3) step();
    check("fl_nothing_emerges", 64'(out_valid), 64'd0);

    // Reset while FULL
    out_ready = 1'b0;
    send(32'h800000B7, 32'h400);
    check("rs_full", 64'(out_valid), 64'd1);
    check("rs_imm_before", 64'(out_imm), 64'h80000000);
    rst_n = 1'b0;
    #1;
    check("rs_ready_in_reset", 64'(in_ready), 64'd0);
    step();
    check("rs_out_valid", 64'(out_valid), 64'd0);
    check("rs_out_imm", 64'(out_imm), 64'd0);
    check("rs_ready_held", 64'(in_ready), 64'd0);
    rst_n = 1'b1;
    step();
    check("rs_ready_after", 64'(in_ready), 64'd1);
    check("rs_still_empty", 64'(out_valid), 64'd0);

    // Unknown opcode
    out_ready = 1'b1;
    send(32'h0000007F, 32'h500);
    check("ill_fmt", 64'(out_fmt), 64'd7);
    check("ill_imm", 64'(out_imm), 64'd0);
`ifdef DECODE_ILLEGAL_CHECK_EN
    check("ill_flag", 64'(out_illegal), 64'd1);
`else
    check("ill_flag", 64'(out_illegal), 64'd0);
`endif
    step();
    check("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
